// File: rtl/vga_ip_pkg.sv
// -----------------------------------------------------------------------------
// vga_ip_pkg
// Shared constants for the VGA IP control space: AXI response codes, the byte
// offsets of the four control registers and a helper that tells whether a
// word slot index maps onto an implemented register.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_ip_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int NUM_CTRL_REGS = 4;

   // Word slot index width for a 5-bit byte address (8 slots).
   localparam int SLOT_IDX_W = 3;

   localparam logic [4:0] CTRL_REG0_OFS = 5'h00;
   localparam logic [4:0] CTRL_REG1_OFS = 5'h04;
   localparam logic [4:0] CTRL_REG2_OFS = 5'h08;
   localparam logic [4:0] CTRL_REG3_OFS = 5'h0C;

   // Slots 0..3 hold registers; 4..7 are decoded but empty.
   function automatic logic slot_impl(input logic [SLOT_IDX_W-1:0] idx);
      return idx < SLOT_IDX_W'(NUM_CTRL_REGS);
   endfunction

endpackage

// File: rtl/vga_ctrl_regbank.sv
// -----------------------------------------------------------------------------
// vga_ctrl_regbank
// Storage for the four VGA control registers with a bytewise strobed write
// port and a combinational read mux. Writes or reads aimed at slots 4..7 are
// dropped / return zero.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_we                  write enable (one commit per asserted cycle)
//   i_widx, i_wdata,      write slot index, data and byte strobes
//   i_wstrb
//   i_ridx                read slot index
//   o_rdata               read data for i_ridx (0 for empty slots)
//   o_reg0..o_reg3        live register contents
// -----------------------------------------------------------------------------
module vga_ctrl_regbank
   import vga_ip_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_we,
   input  logic [SLOT_IDX_W-1:0] i_widx,
   input  logic [31:0]           i_wdata,
   input  logic [3:0]            i_wstrb,
   input  logic [SLOT_IDX_W-1:0] i_ridx,
   output logic [31:0]           o_rdata,
   output logic [31:0]           o_reg0,
   output logic [31:0]           o_reg1,
   output logic [31:0]           o_reg2,
   output logic [31:0]           o_reg3
);

   logic [31:0] r_regs [NUM_CTRL_REGS];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_CTRL_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && slot_impl(i_widx)) begin
         for (int b = 0; b < 4; b++) begin
            if (i_wstrb[b]) begin
               r_regs[i_widx[1:0]][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      o_rdata = '0;
      if (slot_impl(i_ridx)) begin
         o_rdata = r_regs[i_ridx[1:0]];
      end
   end

   assign o_reg0 = r_regs[0];
   assign o_reg1 = r_regs[1];
   assign o_reg2 = r_regs[2];
   assign o_reg3 = r_regs[3];

endmodule

// File: rtl/vga_ctrl_axil_slave.sv
// -----------------------------------------------------------------------------
// vga_ctrl_axil_slave
// AXI4-Lite responder for the VGA IP control space. Four 32-bit registers at
// byte offsets 0x00..0x0C, driven straight out to the VGA core.
// Write path: AW and W are captured independently into holding registers
// (either order, or together); the register is committed on the first edge
// where both are held, which also raises BVALID. No new AW/W is accepted
// while BVALID is up. Read path: one outstanding read, RDATA registered on
// the AR handshake.
// Configuration macro:
//   VGA_CTRL_AXIL_SLVERR_EN  when defined, accesses to empty slots 4..7
//                            answer SLVERR instead of OKAY.
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN          clock, asynchronous active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B*    AXI4-Lite write channels
//   S_AXI_AR* / S_AXI_R*               AXI4-Lite read channels
//   ctrl_reg0..ctrl_reg3               register contents to the VGA core
// -----------------------------------------------------------------------------
module vga_ctrl_axil_slave
   import vga_ip_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
)(
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [31:0]                     ctrl_reg0,
   output logic [31:0]                     ctrl_reg1,
   output logic [31:0]                     ctrl_reg2,
   output logic [31:0]                     ctrl_reg3
);

   localparam int IDX_LSB = 2;

`ifdef VGA_CTRL_AXIL_SLVERR_EN
   localparam logic [1:0] UNIMPL_RESP = RESP_SLVERR;
`else
   localparam logic [1:0] UNIMPL_RESP = RESP_OKAY;
`endif

   function automatic logic [1:0] slot_resp(input logic [SLOT_IDX_W-1:0] idx);
      return slot_impl(idx) ? RESP_OKAY : UNIMPL_RESP;
   endfunction

   // Write channel state
   logic                  r_aw_held;
   logic                  r_w_held;
   logic [SLOT_IDX_W-1:0] r_aw_idx;
   logic [31:0]           r_wdata;
   logic [3:0]            r_wstrb;
   logic                  r_bvalid;
   logic [1:0]            r_bresp;

   // Read channel state
   logic                  r_rvalid;
   logic [31:0]           r_rdata;
   logic [1:0]            r_rresp;

   logic                  w_awready;
   logic                  w_wready;
   logic                  w_arready;
   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_ar_hs;
   logic                  w_commit;
   logic [SLOT_IDX_W-1:0] w_aw_idx;
   logic [SLOT_IDX_W-1:0] w_ar_idx;
   logic [31:0]           w_rb_rdata;

   // Byte-lane bits of the addresses and the PROT fields carry no meaning here.
   logic w_unused;
   assign w_unused = &{1'b0, S_AXI_AWADDR[IDX_LSB-1:0], S_AXI_ARADDR[IDX_LSB-1:0],
                       S_AXI_AWPROT, S_AXI_ARPROT};

   assign w_aw_idx = S_AXI_AWADDR[IDX_LSB +: SLOT_IDX_W];
   assign w_ar_idx = S_AXI_ARADDR[IDX_LSB +: SLOT_IDX_W];

   // READY comes only from held state, never from VALID, so no comb loops
   // through the interconnect.
   assign w_awready = !r_aw_held && !r_bvalid;
   assign w_wready  = !r_w_held  && !r_bvalid;
   assign w_arready = !r_rvalid;

   assign w_aw_hs  = S_AXI_AWVALID && w_awready;
   assign w_w_hs   = S_AXI_WVALID  && w_wready;
   assign w_ar_hs  = S_AXI_ARVALID && w_arready;
   assign w_commit = r_aw_held && r_w_held;

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
      end else if (w_commit) begin
         // Both holders are full, so neither channel can handshake this cycle
         // and BVALID is known low.
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_bvalid  <= 1'b1;
         r_bresp   <= slot_resp(r_aw_idx);
      end else begin
         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
         end
         if (w_w_hs) begin
            r_w_held <= 1'b1;
         end
         if (r_bvalid && S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   // Payload holders only load on their own handshake; the held flags qualify
   // them, so they need no reset.
   always_ff @(posedge S_AXI_ACLK) begin
      if (w_aw_hs) begin
         r_aw_idx <= w_aw_idx;
      end
      if (w_w_hs) begin
         r_wdata <= S_AXI_WDATA[31:0];
         r_wstrb <= S_AXI_WSTRB[3:0];
      end
   end

   // The read samples the bank before this edge's commit lands, so a read and
   // write to the same register in one cycle returns the old value.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= RESP_OKAY;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_rb_rdata;
         r_rresp  <= slot_resp(w_ar_idx);
      end else if (r_rvalid && S_AXI_RREADY) begin
         r_rvalid <= 1'b0;
      end
   end

   vga_ctrl_regbank u_regbank (
      .i_clk   (S_AXI_ACLK),
      .i_rst_n (S_AXI_ARESETN),
      .i_we    (w_commit),
      .i_widx  (r_aw_idx),
      .i_wdata (r_wdata),
      .i_wstrb (r_wstrb),
      .i_ridx  (w_ar_idx),
      .o_rdata (w_rb_rdata),
      .o_reg0  (ctrl_reg0),
      .o_reg1  (ctrl_reg1),
      .o_reg2  (ctrl_reg2),
      .o_reg3  (ctrl_reg3)
   );

   assign S_AXI_AWREADY = w_awready;
   assign S_AXI_WREADY  = w_wready;
   assign S_AXI_ARREADY = w_arready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RDATA   = C_S_AXI_DATA_WIDTH'(r_rdata);
   assign S_AXI_RRESP   = r_rresp;

endmodule

// File: tb/tb_vga_ctrl_axil_slave.sv
// -----------------------------------------------------------------------------
// tb_vga_ctrl_axil_slave
// Bench for vga_ctrl_axil_slave: directed scenarios followed by randomized
// concurrent read/write traffic, all outputs compared every cycle against a
// transaction-level model (register array plus AW/W holding queues).
// Honours VGA_CTRL_AXIL_SLVERR_EN for the expected empty-slot response.
// -----------------------------------------------------------------------------
module tb_vga_ctrl_axil_slave;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [4:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
   logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
   logic [31:0] S_AXI_RDATA;
   logic [31:0] ctrl_reg0, ctrl_reg1, ctrl_reg2, ctrl_reg3;

   vga_ctrl_axil_slave dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (rready),
      .ctrl_reg0     (ctrl_reg0),
      .ctrl_reg1     (ctrl_reg1),
      .ctrl_reg2     (ctrl_reg2),
      .ctrl_reg3     (ctrl_reg3)
   );

`ifdef VGA_CTRL_AXIL_SLVERR_EN
   localparam logic [1:0] EXP_UNIMPL = 2'b10;
`else
   localparam logic [1:0] EXP_UNIMPL = 2'b00;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: registers, pending AW slots and pending W beats.
   logic [31:0] m_regs [4];
   int          aw_q [$];
   logic [35:0] w_q  [$];
   logic        m_bv, m_rv;
   logic [1:0]  m_br, m_rr;
   logic [31:0] m_rd;
   logic        hs_aw, hs_w, hs_ar, hs_b, hs_r;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] exp_resp(input int idx);
      return (idx < 4) ? 2'b00 : EXP_UNIMPL;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
      aw_q.delete();
      w_q.delete();
      m_bv = 0; m_rv = 0; m_br = 0; m_rr = 0; m_rd = 0;
      hs_aw = 0; hs_w = 0; hs_ar = 0; hs_b = 0; hs_r = 0;
   endtask

   // Advance the model by one clock edge using the inputs seen at that edge.
   task automatic model_update();
      bit aw_ok, w_ok, do_commit;
      int idx;
      logic [35:0] wb;
      if (!rst_n) begin
         model_reset();
         return;
      end
      aw_ok     = (aw_q.size() == 0) && !m_bv;
      w_ok      = (w_q.size() == 0) && !m_bv;
      hs_aw     = awvalid && aw_ok;
      hs_w      = wvalid && w_ok;
      hs_ar     = arvalid && !m_rv;
      hs_b      = m_bv && bready;
      hs_r      = m_rv && rready;
      do_commit = (aw_q.size() > 0) && (w_q.size() > 0);
      if (hs_ar) begin
         idx  = int'(araddr[4:2]);
         m_rd = (idx < 4) ? m_regs[idx] : 32'h0;
         m_rv = 1;
         m_rr = exp_resp(idx);
      end else if (hs_r) begin
         m_rv = 0;
      end
      if (do_commit) begin
         idx = aw_q.pop_front();
         wb  = w_q.pop_front();
         if (idx < 4)
            for (int b = 0; b < 4; b++)
               if (wb[32+b]) m_regs[idx][8*b +: 8] = wb[8*b +: 8];
         m_bv = 1;
         m_br = exp_resp(idx);
      end else if (hs_b) begin
         m_bv = 0;
      end
      if (hs_aw) aw_q.push_back(int'(awaddr[4:2]));
      if (hs_w)  w_q.push_back({wstrb, wdata});
   endtask

   task automatic compare_all();
      if (!rst_n) begin
         model_reset();
         chk("rst_rdata", S_AXI_RDATA, 32'h0);
         chk("rst_bresp", 32'(S_AXI_BRESP), 32'h0);
         chk("rst_rresp", 32'(S_AXI_RRESP), 32'h0);
      end
      chk("awready", 32'(S_AXI_AWREADY), 32'((aw_q.size() == 0) && !m_bv));
      chk("wready",  32'(S_AXI_WREADY),  32'((w_q.size() == 0) && !m_bv));
      chk("arready", 32'(S_AXI_ARREADY), 32'(!m_rv));
      chk("bvalid",  32'(S_AXI_BVALID),  32'(m_bv));
      chk("rvalid",  32'(S_AXI_RVALID),  32'(m_rv));
      if (m_bv) chk("bresp", 32'(S_AXI_BRESP), 32'(m_br));
      if (m_rv) begin
         chk("rdata", S_AXI_RDATA, m_rd);
         chk("rresp", 32'(S_AXI_RRESP), 32'(m_rr));
      end
      chk("ctrl_reg0", ctrl_reg0, m_regs[0]);
      chk("ctrl_reg1", ctrl_reg1, m_regs[1]);
      chk("ctrl_reg2", ctrl_reg2, m_regs[2]);
      chk("ctrl_reg3", ctrl_reg3, m_regs[3]);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_all();
   endtask

   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      int  n = 0;
      bit  done = 0;
      resp = 2'bxx;
      awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1; bready = 1;
      while (!done && n < 30) begin
         cycle();
         n++;
         if (hs_aw) awvalid = 0;
         if (hs_w)  wvalid = 0;
         if (hs_b) done = 1;
         else if (m_bv) resp = S_AXI_BRESP;
      end
      awvalid = 0; wvalid = 0;
      if (!done) chk("wr_timeout", 32'h0, 32'h1);
   endtask

   task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n = 0;
      bit done = 0;
      d = 32'hxxxxxxxx; resp = 2'bxx;
      araddr = a; arvalid = 1; rready = 1;
      while (!done && n < 30) begin
         cycle();
         n++;
         if (hs_ar) arvalid = 0;
         if (hs_r) done = 1;
         else if (m_rv) begin
            d = S_AXI_RDATA;
            resp = S_AXI_RRESP;
         end
      end
      arvalid = 0;
      if (!done) chk("rd_timeout", 32'h0, 32'h1);
   endtask

   initial begin : stim
      logic [31:0] rd;
      logic [1:0]  rs;
      logic [31:0] vals [4];
      int          n;

      vals[0] = 32'h0101FFFF; vals[1] = 32'hABCD0001;
      vals[2] = 32'hDEAD0011; vals[3] = 32'hBEEF0011;
      rst_n = 1;
      awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
      awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
      wdata = 0; wstrb = 0;
      model_reset();
      #1 rst_n = 0;
      #1 compare_all();
      cycle();
      cycle();
      rst_n = 1;
      cycle();
      chk("rel_awready", 32'(S_AXI_AWREADY), 32'h1);
      chk("rel_wready",  32'(S_AXI_WREADY),  32'h1);
      chk("rel_arready", 32'(S_AXI_ARREADY), 32'h1);

      // Basic write/readback of all four registers.
      for (int i = 0; i < 4; i++) begin
         axi_write(5'(4*i), vals[i], 4'hF, rs);
         chk("wr_bresp", 32'(rs), 32'h0);
         axi_read(5'(4*i), rd, rs);
         chk("rd_back", rd, vals[i]);
         chk("rd_rresp", 32'(rs), 32'h0);
      end
      chk("lit_reg0", ctrl_reg0, 32'h0101FFFF);
      chk("lit_reg1", ctrl_reg1, 32'hABCD0001);
      chk("lit_reg2", ctrl_reg2, 32'hDEAD0011);
      chk("lit_reg3", ctrl_reg3, 32'hBEEF0011);

      // W three cycles ahead of AW.
      wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1; bready = 1;
      for (int k = 0; k < 3; k++) begin
         cycle();
         if (hs_w) wvalid = 0;
         chk("early_reg1_hold", ctrl_reg1, 32'hABCD0001);
      end
      awaddr = 5'h04; awvalid = 1;
      cycle();
      awvalid = 0;
      chk("early_no_bvalid", 32'(S_AXI_BVALID), 32'h0);
      chk("early_reg1_old", ctrl_reg1, 32'hABCD0001);
      cycle();
      chk("early_bvalid", 32'(S_AXI_BVALID), 32'h1);
      chk("early_reg1_new", ctrl_reg1, 32'hCAFEF00D);
      cycle();

      // Partial strobes.
      axi_write(5'h08, 32'hAAAAAAAA, 4'hF, rs);
      axi_write(5'h08, 32'h11223344, 4'b0101, rs);
      axi_read(5'h08, rd, rs);
      chk("strb_rd", rd, 32'hAA22AA44);

      // BREADY held low after commit: response holds, channels stay closed.
      awaddr = 5'h0C; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
      n = 0;
      while (!m_bv && n < 10) begin
         cycle();
         n++;
         if (hs_aw) awvalid = 0;
         if (hs_w)  wvalid = 0;
      end
      if (!m_bv) chk("hold_timeout", 32'h0, 32'h1);
      awvalid = 0; wvalid = 0;
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("hold_bvalid",  32'(S_AXI_BVALID),  32'h1);
         chk("hold_bresp",   32'(S_AXI_BRESP),   32'h0);
         chk("hold_awready", 32'(S_AXI_AWREADY), 32'h0);
         chk("hold_wready",  32'(S_AXI_WREADY),  32'h0);
      end
      bready = 1;
      cycle();
      chk("hold_release", 32'(S_AXI_BVALID), 32'h0);
      axi_write(5'h0C, 32'h0055AA00, 4'hF, rs);
      chk("hold_next_reg3", ctrl_reg3, 32'h0055AA00);

      // Empty slot 0x10.
      axi_write(5'h10, 32'hFFFFFFFF, 4'hF, rs);
      chk("slot4_bresp", 32'(rs), 32'(EXP_UNIMPL));
      axi_read(5'h10, rd, rs);
      chk("slot4_rdata", rd, 32'h0);
      chk("slot4_rresp", 32'(rs), 32'(EXP_UNIMPL));
      chk("slot4_reg0", ctrl_reg0, 32'h0101FFFF);
      chk("slot4_reg1", ctrl_reg1, 32'hCAFEF00D);
      chk("slot4_reg2", ctrl_reg2, 32'hAA22AA44);
      chk("slot4_reg3", ctrl_reg3, 32'h0055AA00);

      // Read and commit to the same register on one edge: old value returned.
      awaddr = 5'h08; wdata = 32'h77777777; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
      cycle();
      awvalid = 0; wvalid = 0;
      araddr = 5'h08; arvalid = 1; rready = 1;
      cycle();
      arvalid = 0;
      chk("rw_same_rdata", S_AXI_RDATA, 32'hAA22AA44);
      chk("rw_same_reg2", ctrl_reg2, 32'h77777777);
      cycle();
      cycle();

      // Reset with AW held and W pending.
      awaddr = 5'h00; awvalid = 1; bready = 1;
      cycle();
      awvalid = 0;
      wdata = 32'h12121212; wstrb = 4'hF; wvalid = 1;
      #2 rst_n = 0;
      #1 compare_all();
      chk("rstmid_bvalid", 32'(S_AXI_BVALID), 32'h0);
      chk("rstmid_reg0", ctrl_reg0, 32'h0);
      chk("rstmid_reg2", ctrl_reg2, 32'h0);
      wvalid = 0;
      cycle();
      cycle();
      rst_n = 1;
      cycle();
      axi_write(5'h00, 32'h600DF00D, 4'hF, rs);
      chk("rstmid_wr_bresp", 32'(rs), 32'h0);
      axi_read(5'h00, rd, rs);
      chk("rstmid_rd", rd, 32'h600DF00D);

      // Randomized concurrent traffic.
      for (int i = 0; i < 3000; i++) begin
         if (!awvalid || hs_aw) begin
            awvalid = ($urandom_range(0, 3) != 0);
            awaddr  = 5'($urandom_range(0, 31));
            awprot  = 3'($urandom_range(0, 7));
         end
         if (!wvalid || hs_w) begin
            wvalid = ($urandom_range(0, 3) != 0);
            wdata  = $urandom;
            wstrb  = 4'($urandom_range(0, 15));
         end
         if (!arvalid || hs_ar) begin
            arvalid = ($urandom_range(0, 2) != 0);
            araddr  = 5'($urandom_range(0, 31));
            arprot  = 3'($urandom_range(0, 7));
         end
         bready = ($urandom_range(0, 3) != 0);
         rready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
      repeat (5) cycle();
      for (int i = 0; i < 4; i++) begin
         axi_read(5'(4*i), rd, rs);
         chk("final_rd", rd, m_regs[i]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_ctrl_axil_slave.md
# vga_ctrl_axil_slave

AXI4-Lite responder for the VGA IP control space: accepts master write/read transactions and exposes four 32-bit read/write control registers at word offsets 0x0–0xC. It sits between the block-design AXI interconnect (or the AXI4-Lite master BFM in simulation) and the VGA timing/pixel core, which consumes the register contents directly. Address and data channels are handled independently. Every transaction completes with a response.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5: byte address width; 8 word slots, 4 implemented (0x00–0x0C).
- S_AXI_ACLK  in  1  single clock; all logic on its rising edge.
- S_AXI_ARESETN  in  1  reset, asynchronous assert and active-low.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address; bits [1:0] ignored.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables; byte i is written only if WSTRB[i]=1.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address; bits [1:0] ignored.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- ctrl_reg0..ctrl_reg3  out  32 each  current register contents, driven to the VGA core.

## Operation
- Write path uses flags aw_held and w_held.
- AWREADY = !aw_held && !BVALID. WREADY = !w_held && !BVALID. Neither depends combinationally on its VALID.
- An AW handshake latches the word index; a W handshake latches data and strobes. They may occur in either order or in the same cycle.
- Commit: on the first edge where both flags are set:
  - update the addressed register bytewise per strobes;
  - set BVALID with BRESP=OKAY;
  - clear both flags.
- BVALID holds, with BRESP stable, until the BREADY edge. No new AW/W is accepted while BVALID=1.
- Read path: ARREADY = !RVALID. On the AR handshake edge, RDATA is loaded from the addressed register and RVALID=1, RRESP=OKAY. RVALID, RDATA and RRESP hold until the RREADY edge.
- Unimplemented slot (index 4–7):
  - write discarded;
  - read returns 0x00000000;
  - response per Configuration.
- Simultaneous read and write commit to the same register in one cycle: read returns the pre-write value.
- Reset: all registers 0x00000000. AWREADY, WREADY and ARREADY read 1 once reset is released. BVALID=0, RVALID=0, RDATA=0, BRESP=RRESP=00, held flags cleared.
- Reset mid-transaction abandons it; no partial register update.

## Timing
- Write: AW and W handshake at edge N → register and ctrl_regX updated, BVALID=1 at edge N+1.
- AW at N, W at N+k → commit at N+k+1.
- Read: AR handshake at edge N → RVALID=1 and RDATA valid after edge N.
- With RREADY held high: RVALID=1 for one cycle; ARREADY returns to 1 at N+1, giving at most one read per 2 cycles.
- ctrl_regX changes only on commit edges.

## Configuration
- VGA_CTRL_AXIL_SLVERR_EN defined: accesses to slots 4–7 return SLVERR (2'b10) on BRESP/RRESP.
- Macro absent: those accesses return OKAY. Data behaviour (write discarded, read 0) is identical in both cases.

## Structure
- Shared package vga_ip_pkg:
  - RESP_OKAY / RESP_SLVERR constants;
  - register offsets CTRL_REG0_OFS..CTRL_REG3_OFS;
  - NUM_CTRL_REGS=4.
- One sub-module: vga_ctrl_regbank, holding the register storage, bytewise strobe write and read mux. The top level holds both AXI channel FSMs.

## Test plan
- Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x0, 0x4, 0x8, 0xC, each followed by a read of the same address → each read returns the written value; all responses OKAY; ctrl_reg0..3 match.
- W presented 3 cycles before AW (0xCAFEF00D to 0x4) → no update until AW handshake; BVALID one edge after AW; ctrl_reg1=0xCAFEF00D.
- WSTRB=4'b0101, data 0x11223344 over existing 0xAAAAAAAA at 0x8 → reads 0xAA22AA44.
- BREADY held low 5 cycles after commit → BVALID/BRESP stable; AWREADY=WREADY=0 throughout; next write accepted after the BREADY edge.
- Read/write to 0x10:
  - with VGA_CTRL_AXIL_SLVERR_EN → BRESP=RRESP=2'b10, RDATA=0;
  - without the macro → OKAY, RDATA=0;
  - in both cases registers unchanged.
- Assert S_AXI_ARESETN low while AW is held and W is pending → registers 0 and BVALID=0 immediately; first write after release completes normally.
